// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read side: sizes, prefetch buffer states
// and the parity helper used when RD_PARITY_EN is defined.
package fifo_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Stored parity bit: set when the payload carries an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-slot head/tail prefetch register for the FIFO read stream; the head slot
// drives the stream payload directly, so the output is fully registered.
module rd_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);
  import fifo_pkg::*;

  buf_state_e        state, state_nxt;
  logic [DATA_W-1:0] tail, head_nxt, tail_nxt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  // Flush wins over everything, which is what makes a pop in the flush cycle void.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (ld) begin
            state_nxt = ONE;
            head_nxt  = din;
          end
        end
        ONE: begin
          if (ld && pop) begin
            head_nxt = din;
          end else if (ld) begin
            state_nxt = TWO;
            tail_nxt  = din;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_nxt = tail;
            if (ld) tail_nxt = din;
            else    state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign valid = (state != EMPTY);
  assign cnt   = state;

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
    !(state == TWO && ld && !pop && !flush));

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side output stage of the async FIFO: issues rinc against buffer credit and
// hides the memory read latency. Optional parity check under RD_PARITY_EN.
module fifo_rd_prefetch #(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  output logic              rinc,
`ifdef RD_PARITY_EN
  input  logic [DATA_W:0]   mem_rdata,
`else
  input  logic [DATA_W-1:0] mem_rdata,
`endif
  input  logic              rflush,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              rperr
);
  import fifo_pkg::*;

  logic              infl;
  logic              pop;
  logic              ld;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic [DATA_W-1:0] payload;

  assign pop = m_valid & m_ready;
  assign ld  = infl & !rflush;

  // Credit counts the in-flight word too, so buffered + in-flight never exceeds two.
  assign occ  = 3'(cnt) + 3'(infl) - 3'(pop);
  assign rinc = rrst_n & !rempty & !rflush & (occ < 3'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) infl <= 1'b0;
    else         infl <= rinc;
  end

`ifdef RD_PARITY_EN
  logic rperr_q;

  assign payload = mem_rdata[DATA_W-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)
      rperr_q <= 1'b0;
    else if (ld && (mem_rdata[DATA_W] != odd_parity(payload)))
      rperr_q <= 1'b1;
  end

  assign rperr = rperr_q;
`else
  assign payload = mem_rdata;
  assign rperr   = 1'b0;
`endif

  rd_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .ld     (ld),
    .din    (payload),
    .pop    (pop),
    .flush  (rflush),
    .valid  (m_valid),
    .head   (m_data),
    .cnt    (cnt)
  );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Scoreboard bench for fifo_rd_prefetch: a FIFO/memory model feeds the DUT and a
// negedge monitor compares every accepted beat against the expected-word queue.
module tb_fifo_rd_prefetch;
  import fifo_pkg::*;

  localparam int DW = fifo_pkg::DATA_W;
`ifdef RD_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  logic          rclk    = 1'b0;
  logic          rrst_n  = 1'b0;
  logic          rempty  = 1'b1;
  logic          rflush  = 1'b0;
  logic          m_ready = 1'b0;
  logic [MW-1:0] mem_rdata = '0;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          rperr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int handed = 0;
  int taken = 0;
  int rinc_cnt = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  logic [MW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 rclk = ~rclk;

  fifo_rd_prefetch #(.DATA_W(DW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rinc      (rinc),
    .mem_rdata (mem_rdata),
    .rflush    (rflush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .rperr     (rperr)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Upstream model: read pointer pops on rinc, memory word appears the next cycle.
  always @(posedge rclk) begin
    cyc++;
    if (rinc) begin
      mem_rdata <= fifo_q.pop_front();
      handed++;
    end
    if (rflush) begin
      repeat (handed - taken) void'(exp_q.pop_front());
      handed = taken;
    end
    rempty <= (fifo_q.size() == 0);
  end

  always @(negedge rclk) begin
    if (rinc) rinc_cnt++;
    if (rrst_n && m_valid && m_ready && !rflush) begin
      beat_cnt++;
      taken++;
      if (beat_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat: got unexpected word 0x%0h, expected no beat", m_data);
      end else begin
        check_output("data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_raw(input logic [MW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w[DW-1:0]);
    rempty = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    logic [MW-1:0] w;
`ifdef RD_PARITY_EN
    w = {^d, d};
`else
    w = d;
`endif
    push_raw(w);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    handed = 0;
    taken = 0;
    rempty = 1'b1;
  endtask

  task automatic clear_counts();
    rinc_cnt = 0;
    beat_cnt = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 200) begin
      @(negedge rclk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL %s: drain timeout, got %0d words pending, expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge rclk);
  endtask

  task automatic apply_stimulus();
    int n;
    int t0;
    logic [DW-1:0] held;

    // Reset with words already queued upstream.
    do_reset();
    for (int i = 0; i < 3; i++) push_word(DW'(8'hA1 + i));
    m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    check_output("rst_rinc", 32'(rinc), 0);
    check_output("rst_valid", 32'(m_valid), 0);
    check_output("rst_data", 32'(m_data), 0);
    check_output("rst_rperr", 32'(rperr), 0);
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    n = 0;
    @(negedge rclk);
    while (!rinc && n < 10) begin @(negedge rclk); n++; end
    t0 = cyc;
    n = 0;
    @(negedge rclk);
    while (!m_valid && n < 10) begin @(negedge rclk); n++; end
    check_output("first_latency", 32'(cyc - t0), 2);
    drain("reset_words");

    // Full-rate burst.
    clear_counts();
    for (int i = 0; i < 16; i++) push_word(DW'(8'h10 + i));
    drain("burst");
    check_output("burst_rinc", 32'(rinc_cnt), 16);
    check_output("burst_beats", 32'(beat_cnt), 16);
    check_output("burst_span", 32'(last_cyc - first_cyc + 1), 16);

    // Backpressure mid-burst.
    for (int i = 0; i < 10; i++) push_word(DW'(8'h40 + i));
    repeat (4) @(negedge rclk);
    @(posedge rclk); #1;
    m_ready = 1'b0;
    @(negedge rclk);
    held = m_data;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      check_output("stall_rinc", 32'(rinc), 0);
      check_output("stall_data", 32'(m_data), 32'(held));
    end
    check_output("stall_valid", 32'(m_valid), 1);
    @(posedge rclk); #1;
    m_ready = 1'b1;
    drain("backpressure");

    // Single word then empty.
    clear_counts();
    push_word(DW'(8'h77));
    repeat (10) @(negedge rclk);
    check_output("one_rinc", 32'(rinc_cnt), 1);
    check_output("one_beats", 32'(beat_cnt), 1);
    check_output("empty_rinc", 32'(rinc), 0);

    // Flush with a full buffer: the two buffered words are discarded.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'(8'h60 + i));
    repeat (6) @(negedge rclk);
    check_output("full_valid", 32'(m_valid), 1);
    @(posedge rclk); #1;
    rflush = 1'b1;
    @(negedge rclk);
    check_output("flush_rinc", 32'(rinc), 0);
    @(posedge rclk); #1;
    rflush = 1'b0;
    @(negedge rclk);
    check_output("flush_valid", 32'(m_valid), 0);
    m_ready = 1'b1;
    drain("flush_full");

    // Flush with a word in flight: that word is dropped.
    for (int i = 0; i < 3; i++) push_word(DW'(8'h80 + i));
    n = 0;
    while (!rinc && n < 10) begin @(negedge rclk); n++; end
    @(posedge rclk); #1;
    rflush = 1'b1;
    @(posedge rclk); #1;
    rflush = 1'b0;
    @(negedge rclk);
    check_output("flush_infl_valid", 32'(m_valid), 0);
    drain("flush_infl");

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) push_word(DW'(8'hC0 + i));
    repeat (4) @(negedge rclk);
    @(posedge rclk); #2;
    do_reset();
    #1;
    check_output("midrst_valid", 32'(m_valid), 0);
    check_output("midrst_rinc", 32'(rinc), 0);
    repeat (2) @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    push_word(DW'(8'hD1));
    push_word(DW'(8'hD2));
    drain("after_reset");

`ifdef RD_PARITY_EN
    push_raw(MW'(9'h0A5));
    drain("par_good");
    check_output("rperr_good", 32'(rperr), 0);
    push_raw(MW'(9'h1A5));
    drain("par_bad");
    check_output("rperr_bad", 32'(rperr), 1);
    push_raw(MW'(9'h03C));
    drain("par_sticky");
    check_output("rperr_sticky", 32'(rperr), 1);
`else
    check_output("rperr_tied", 32'(rperr), 0);
`endif

    check_output("scoreboard_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    apply_stimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
